conv3x3_mac_stream: RTL

- Consumes the 3x3 window stream produced by the stride-1/padding-1 kernel window generator: nine pixels per cycle plus a valid strobe.
- Multiplies each window by a loaded 3x3 weight set in signed fixed point and sums the products through a pipelined adder tree.
- Emits one rounded, saturated output pixel per window, in raster order, with row/column position and an end-of-frame pulse.
- Sits directly after the window generator and forms the output end of the convolution datapath.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/fxp_round_sat.sv | 35 +++
 rtl/conv3x3_mac_stream.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the convolution datapath: FSM encoding, fixed-point
// format defaults and the signed saturation bounds of the default data width.
package conv_pkg;

    // Default arithmetic format: Q16.16 in a 32-bit signed word.
    localparam int DATA_WIDHT_DEF = 32;
    localparam int FRAC_BITS_DEF  = 16;

    // Half an LSB of the result, added before the truncating shift.
    localparam longint ROUND_CONST = longint'(1) << (FRAC_BITS_DEF - 1);

    // Signed range of a DATA_WIDHT_DEF result.
    localparam logic [DATA_WIDHT_DEF-1:0] MAX_POS = {1'b0, {(DATA_WIDHT_DEF-1){1'b1}}};
    localparam logic [DATA_WIDHT_DEF-1:0] MAX_NEG = {1'b1, {(DATA_WIDHT_DEF-1){1'b0}}};

    // Weight-load / run controller states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturation of a wide
// signed accumulator down to an OUT_W signed fixed-point word.
module fxp_round_sat #(
    parameter int IN_W  = 68,
    parameter int OUT_W = 32,
    parameter int FRAC  = 16
) (
    input  logic signed [IN_W-1:0]  sum_i,
    output logic        [OUT_W-1:0] res_o,
    output logic                    sat_o
);
    // Rounding constant and the output range, expressed at the input width.
    localparam logic signed [IN_W-1:0] RND = IN_W'(1) << (FRAC - 1);
    localparam logic signed [IN_W-1:0] HI  = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] LO  = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0] rounded;
    logic signed [IN_W-1:0] shifted;

    // Round, rescale, then clamp into the signed output range.
    always_comb begin
        rounded = sum_i + RND;
        shifted = rounded >>> FRAC;
        res_o   = shifted[OUT_W-1:0];
        sat_o   = 1'b0;
        if (shifted > HI) begin
            res_o = HI[OUT_W-1:0];
            sat_o = 1'b1;
        end else if (shifted < LO) begin
            res_o = LO[OUT_W-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/conv3x3_mac_stream.sv
// 3x3 convolution MAC on a window stream: weight loader FSM, three-stage
// multiply / partial-sum / round-saturate pipeline and raster position tracking.
// Handshake: a window transfers on a cycle where Valid_in and Ready are both
// high; Ready is high only in RUN; outputs have no backpressure and Valid_Out
// marks Data_Out/Row_Out/Col_Out/Frame_Done for exactly one cycle.
module conv3x3_mac_stream
    import conv_pkg::*;
#(
    parameter int DATA_WIDHT = DATA_WIDHT_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int IMG_WIDHT  = 220,
    parameter int IMG_HEIGHT = 220
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Weight_Start,
    input  logic [DATA_WIDHT-1:0] Weight_In,
    input  logic                  Weight_Valid,
    input  logic [DATA_WIDHT-1:0] Data_In1,
    input  logic [DATA_WIDHT-1:0] Data_In2,
    input  logic [DATA_WIDHT-1:0] Data_In3,
    input  logic [DATA_WIDHT-1:0] Data_In4,
    input  logic [DATA_WIDHT-1:0] Data_In5,
    input  logic [DATA_WIDHT-1:0] Data_In6,
    input  logic [DATA_WIDHT-1:0] Data_In7,
    input  logic [DATA_WIDHT-1:0] Data_In8,
    input  logic [DATA_WIDHT-1:0] Data_In9,
    input  logic                  Valid_in,
    output logic                  Ready,
    output logic [DATA_WIDHT-1:0] Data_Out,
    output logic                  Valid_Out,
    output logic [7:0]            Row_Out,
    output logic [7:0]            Col_Out,
    output logic                  Frame_Done,
    output logic                  Sat_Flag
);
    localparam int PROD_W = 2 * DATA_WIDHT;
    localparam int PSUM_W = PROD_W + 2;
    localparam int SUM_W  = PROD_W + 4;   // nine full-scale products need 4 guard bits
    localparam logic [7:0] LAST_COL = 8'(IMG_WIDHT - 1);
    localparam logic [7:0] LAST_ROW = 8'(IMG_HEIGHT - 1);

    logic [DATA_WIDHT-1:0] pix [9];
    assign pix = '{Data_In1, Data_In2, Data_In3, Data_In4, Data_In5,
                   Data_In6, Data_In7, Data_In8, Data_In9};

    logic [1:0]               state_q, state_d;
    logic [3:0]               idx_q, idx_d;
    logic [DATA_WIDHT-1:0]    w_q [9];
    logic [DATA_WIDHT-1:0]    w_d [9];
    logic signed [PROD_W-1:0] prod_q [9];
    logic signed [PROD_W-1:0] prod_d [9];
    logic signed [PSUM_W-1:0] psum_q [3];
    logic signed [PSUM_W-1:0] psum_d [3];
    logic                     v1_q, v1_d, v2_q, v2_d;
    logic [DATA_WIDHT-1:0]    data_out_q, data_out_d;
    logic                     valid_out_q, valid_out_d;
    logic [7:0]               row_q, row_d, col_q, col_d;
    logic [7:0]               pos_row_q, pos_row_d, pos_col_q, pos_col_d;
    logic                     frame_done_q, frame_done_d;
    logic                     sat_q, sat_d;
    logic                     clr_pend_q, clr_pend_d;
    logic                     accept;
    logic signed [SUM_W-1:0]  sum_s3;
    logic [DATA_WIDHT-1:0]    rs_res;
    logic                     rs_sat;

    assign Ready  = (state_q == ST_RUN);
    assign accept = Valid_in && Ready;

    // Weight loader: Weight_Start always restarts loading at w1; nine writes enter RUN.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        w_d     = w_q;
        if (Weight_Start) begin
            state_d = ST_LOAD;
            idx_d   = 4'd0;
            if (Weight_Valid) begin
                w_d[0] = Weight_In;
                idx_d  = 4'd1;
            end
        end else if (state_q == ST_LOAD && Weight_Valid) begin
            w_d[idx_q] = Weight_In;
            idx_d      = idx_q + 4'd1;
            if (idx_q == 4'd8) state_d = ST_RUN;
        end
    end

    // S1/S2: products use the weights current at acceptance, then row partial sums.
    always_comb begin
        v1_d = accept;
        v2_d = v1_q;
        for (int k = 0; k < 9; k++) begin
            prod_d[k] = PROD_W'($signed(pix[k])) * PROD_W'($signed(w_q[k]));
        end
        for (int r = 0; r < 3; r++) begin
            psum_d[r] = PSUM_W'(prod_q[3*r]) + PSUM_W'(prod_q[3*r+1]) + PSUM_W'(prod_q[3*r+2]);
        end
        sum_s3 = SUM_W'(psum_q[0]) + SUM_W'(psum_q[1]) + SUM_W'(psum_q[2]);
    end

    fxp_round_sat #(
        .IN_W (SUM_W),
        .OUT_W(DATA_WIDHT),
        .FRAC (FRAC_BITS)
    ) u_round_sat (
        .sum_i(sum_s3),
        .res_o(rs_res),
        .sat_o(rs_sat)
    );

    // S3 output register, raster position tracking and deferred counter clear.
    always_comb begin
        valid_out_d  = v2_q;
        data_out_d   = v2_q ? rs_res : '0;
        frame_done_d = 1'b0;
        sat_d        = sat_q | (v2_q & rs_sat);
        row_d        = row_q;
        col_d        = col_q;
        pos_row_d    = pos_row_q;
        pos_col_d    = pos_col_q;
        clr_pend_d   = clr_pend_q | Weight_Start;
        if (v2_q) begin
            row_d        = pos_row_q;
            col_d        = pos_col_q;
            frame_done_d = (pos_row_q == LAST_ROW) && (pos_col_q == LAST_COL);
            if (pos_col_q == LAST_COL) begin
                pos_col_d = 8'd0;
                pos_row_d = (pos_row_q == LAST_ROW) ? 8'd0 : pos_row_q + 8'd1;
            end else begin
                pos_col_d = pos_col_q + 8'd1;
            end
        end else if (clr_pend_q && !v1_q && !accept && !Weight_Start) begin
            // Old-weight outputs have all left; next frame starts at (0,0).
            pos_row_d  = 8'd0;
            pos_col_d  = 8'd0;
            clr_pend_d = 1'b0;
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 4'd0;
            w_q          <= '{default: '0};
            prod_q       <= '{default: '0};
            psum_q       <= '{default: '0};
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            row_q        <= 8'd0;
            col_q        <= 8'd0;
            pos_row_q    <= 8'd0;
            pos_col_q    <= 8'd0;
            frame_done_q <= 1'b0;
            sat_q        <= 1'b0;
            clr_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            w_q          <= w_d;
            prod_q       <= prod_d;
            psum_q       <= psum_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            row_q        <= row_d;
            col_q        <= col_d;
            pos_row_q    <= pos_row_d;
            pos_col_q    <= pos_col_d;
            frame_done_q <= frame_done_d;
            sat_q        <= sat_d;
            clr_pend_q   <= clr_pend_d;
        end
    end

    assign Data_Out   = data_out_q;
    assign Valid_Out  = valid_out_q;
    assign Row_Out    = row_q;
    assign Col_Out    = col_q;
    assign Frame_Done = frame_done_q;
    assign Sat_Flag   = sat_q;

endmodule
